fb_port_arbiter: RTL and testbench

Arbitrates port A of a single-bit frame buffer between up to NUM_REQ requesters, such as the moving-objects engine, a sprite blitter and a screen-clear engine. It sits between those requesters and the frame buffer's A_ADDR/A_DATA_IN/A_WE/A_DATA_OUT pins. Arbitration is round-robin with a lock for read-modify-write sequences. Port B (the VGA scan-out side) is not touched.

---
 rtl/fb_arb_pkg.sv | 21 ++
 rtl/fb_port_arbiter_rr_pick.sv | 28 ++
 rtl/fb_port_arbiter.sv | 124 ++++++++++++
 tb/tb_fb_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared constants and helpers for the frame-buffer port A arbiter.
package fb_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int FB_ADDR_WIDTH = 17;
  localparam int FB_MAX_ADDR   = 76799;

  // Wide enough for 8 requesters of up to 32 address bits each.
  localparam int SLICE_VEC_W = 256;

  function automatic logic [31:0] fb_addr_slice(input logic [SLICE_VEC_W-1:0] vec,
                                                input int idx, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'(vec >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first eligible bit at or after start.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt_oh,
  output logic          found
);

  logic [IW:0] idx;

  always_comb begin
    gnt_oh = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!found && elig[idx[IW-1:0]]) begin
        gnt_oh[idx[IW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Round-robin arbiter with RMW lock in front of frame buffer port A.
module fb_port_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = fb_arb_pkg::FB_ADDR_WIDTH,
  parameter int FB_MAX_ADDR = fb_arb_pkg::FB_MAX_ADDR
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              lock,
  input  logic [NUM_REQ-1:0]              we_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_req,
  input  logic [NUM_REQ-1:0]              wdata_req,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic                            rdata,
  output logic                            addr_err,
  output logic [ADDR_WIDTH-1:0]           a_addr,
  output logic                            a_data_in,
  output logic                            a_we,
  input  logic                            a_data_out
);
  import fb_arb_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(FB_MAX_ADDR);

  logic [1:0]            state;
  logic [IW-1:0]         last_grant;
  logic [NUM_REQ-1:0]    owner;
  logic                  rd_req;
  logic                  rd_err;
  logic                  rdata_hold;

  logic [IW-1:0]         start;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    pick_oh;
  logic                  found;
  logic [IW-1:0]         pick_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we, sel_wd, sel_lock, sel_err;
  logic [SLICE_VEC_W-1:0] addr_pad;

  assign addr_pad = SLICE_VEC_W'(addr_req);
  assign start    = (last_grant == IW'(NUM_REQ-1)) ? '0 : last_grant + 1'b1;

  // Masking by the current grant keeps any requester from winning back-to-back.
  always_comb begin
    elig = req & ~gnt;
    if (state == ST_LOCKED) elig = elig & owner;
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .elig   (elig),
    .start  (start),
    .gnt_oh (pick_oh),
    .found  (found)
  );

  always_comb begin
    sel_addr = '0;
    sel_we   = 1'b0;
    sel_wd   = 1'b0;
    sel_lock = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = ADDR_WIDTH'(fb_addr_slice(addr_pad, i, ADDR_WIDTH));
        sel_we   = we_req[i];
        sel_wd   = wdata_req[i];
        sel_lock = lock[i];
        pick_idx = IW'(i);
      end
    end
    sel_err = sel_addr > MAX_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NUM_REQ-1);
      owner      <= '0;
      gnt        <= '0;
      a_addr     <= '0;
      a_we       <= 1'b0;
      a_data_in  <= 1'b0;
      addr_err   <= 1'b0;
      rd_req     <= 1'b0;
      rd_err     <= 1'b0;
      rvalid     <= '0;
      rdata_hold <= 1'b0;
    end else begin
      gnt <= found ? pick_oh : '0;
      if (found) begin
        a_addr     <= sel_addr;
        a_we       <= sel_we & ~sel_err;
        a_data_in  <= sel_wd;
        addr_err   <= sel_err;
        rd_req     <= ~sel_we;
        last_grant <= pick_idx;
        if (sel_lock) begin
          state <= ST_LOCKED;
          owner <= pick_oh;
        end else begin
          state <= ST_GRANT;
          owner <= '0;
        end
      end else begin
        a_we     <= 1'b0;
        addr_err <= 1'b0;
        rd_req   <= 1'b0;
        // An owner that drops REQ while locked keeps the port reserved.
        if (state != ST_LOCKED) state <= ST_IDLE;
      end
      rvalid <= rd_req ? gnt : '0;
      rd_err <= addr_err;
      if (|rvalid) rdata_hold <= rdata;
    end
  end

  // BRAM output is already registered; out-of-range reads return 0.
  assign rdata = (|rvalid) ? (rd_err ? 1'b0 : a_data_out) : rdata_hold;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_fb_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 17;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, lock, we_req, wdata_req;
  logic [N-1:0][AW-1:0] addr;
  logic [N*AW-1:0]   addr_req;
  logic [N-1:0]      gnt, rvalid;
  logic              rdata, addr_err, a_data_in, a_we;
  logic [AW-1:0]     a_addr;
  logic              a_data_out;

  int checks = 0;
  int errors = 0;

  assign addr_req = addr;

  always #5 clk = ~clk;

  fb_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .FB_MAX_ADDR(76799)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we_req(we_req),
    .addr_req(addr_req), .wdata_req(wdata_req), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .addr_err(addr_err), .a_addr(a_addr), .a_data_in(a_data_in),
    .a_we(a_we), .a_data_out(a_data_out)
  );

  // Memory: fixed initial image plus a written-overlay owned by this process only.
  bit mem_val [0:131071];
  bit mem_wr  [0:131071];

  function automatic bit init_val(input logic [AW-1:0] a);
    return (a == 17'd100) || (a == 17'd5) || (a == 17'd76800);
  endfunction

  function automatic bit mem_rd(input logic [AW-1:0] a);
    return mem_wr[a] ? mem_val[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (a_we) begin
      mem_val[a_addr] <= a_data_in;
      mem_wr[a_addr]  <= 1'b1;
    end
    a_data_out <= mem_rd(a_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; lock = '0; we_req = '0; wdata_req = '0; addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_addr_err", 32'(addr_err), 0);
    chk("rst_a_we", 32'(a_we), 0);
    chk("rst_a_addr", 32'(a_addr), 0);
    chk("rst_a_data_in", 32'(a_data_in), 0);

    // Single read by requester 1 of address 100 (holds 1).
    req = 3'b010; addr[1] = 17'd100;
    step();
    chk("rd_gnt", 32'(gnt), 32'b010);
    chk("rd_a_addr", 32'(a_addr), 100);
    chk("rd_a_we", 32'(a_we), 0);
    idle_inputs();
    step();
    chk("rd_rvalid", 32'(rvalid), 32'b010);
    chk("rd_rdata", 32'(rdata), 1);
    step();
    chk("rd_rvalid_off", 32'(rvalid), 0);
    chk("rd_rdata_hold", 32'(rdata), 1);

    // All three write continuously from reset: strict rotation 0,1,2,...
    do_reset();
    req = 3'b111; we_req = 3'b111; wdata_req = 3'b101;
    addr[0] = 17'd10; addr[1] = 17'd11; addr[2] = 17'd12;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << (k % 3)));
      chk($sformatf("rr_we%0d", k), 32'(a_we), 1);
      chk($sformatf("rr_addr%0d", k), 32'(a_addr), 32'(10 + k % 3));
      chk($sformatf("rr_din%0d", k), 32'(a_data_in), 32'((k % 3) != 1));
      if (k == 5) idle_inputs();
    end
    step();
    chk("rr_mem10", 32'(mem_rd(17'd10)), 1);
    chk("rr_mem11", 32'(mem_rd(17'd11)), 0);
    chk("rr_mem12", 32'(mem_rd(17'd12)), 1);

    // RMW lock: requester 2 reads addr 5 locked, others are shut out.
    req = 3'b100; lock = 3'b100; addr[2] = 17'd5;
    step();
    chk("lk_gnt_rd", 32'(gnt), 32'b100);
    chk("lk_addr_rd", 32'(a_addr), 5);
    req = 3'b011; we_req = 3'b011; addr[0] = 17'd20; addr[1] = 17'd21; wdata_req = 3'b011;
    step();
    chk("lk_block1", 32'(gnt), 0);
    chk("lk_rvalid", 32'(rvalid), 32'b100);
    chk("lk_rdata", 32'(rdata), 1);
    step();
    chk("lk_block2", 32'(gnt), 0);
    req = 3'b111; we_req = 3'b111; lock = 3'b000; wdata_req = 3'b011;
    step();
    chk("lk_gnt_wr", 32'(gnt), 32'b100);
    chk("lk_we_wr", 32'(a_we), 1);
    chk("lk_addr_wr", 32'(a_addr), 5);
    req = 3'b011;
    step();
    chk("lk_after0", 32'(gnt), 32'b001);
    req = 3'b010;
    step();
    chk("lk_after1", 32'(gnt), 32'b010);
    idle_inputs();
    step();
    chk("lk_mem5", 32'(mem_rd(17'd5)), 0);
    chk("lk_mem20", 32'(mem_rd(17'd20)), 1);

    // Out-of-range write to 76800 must not reach memory.
    req = 3'b001; we_req = 3'b001; wdata_req = 3'b000; addr[0] = 17'd76800;
    step();
    chk("oor_gnt", 32'(gnt), 32'b001);
    chk("oor_err", 32'(addr_err), 1);
    chk("oor_we", 32'(a_we), 0);
    idle_inputs();
    step();
    chk("oor_err_pulse", 32'(addr_err), 0);
    chk("oor_mem", 32'(mem_rd(17'd76800)), 1);
    // Last legal address is a normal write.
    req = 3'b010; we_req = 3'b010; wdata_req = 3'b010; addr[1] = 17'd76799;
    step();
    chk("max_gnt", 32'(gnt), 32'b010);
    chk("max_err", 32'(addr_err), 0);
    chk("max_we", 32'(a_we), 1);
    idle_inputs();
    step();
    chk("max_mem", 32'(mem_rd(17'd76799)), 1);
    // Out-of-range read returns RVALID with zero data.
    req = 3'b001; addr[0] = 17'd76800;
    step();
    chk("oor_rd_gnt", 32'(gnt), 32'b001);
    chk("oor_rd_err", 32'(addr_err), 1);
    idle_inputs();
    step();
    chk("oor_rd_rvalid", 32'(rvalid), 32'b001);
    chk("oor_rd_rdata", 32'(rdata), 0);

    // Reset asserted while a read is in flight.
    req = 3'b010; addr[1] = 17'd100;
    step();
    chk("mr_gnt", 32'(gnt), 32'b010);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("mr_gnt_clr", 32'(gnt), 0);
    chk("mr_addr_clr", 32'(a_addr), 0);
    chk("mr_rvalid_clr", 32'(rvalid), 0);
    step();
    chk("mr_rvalid_rst", 32'(rvalid), 0);
    chk("mr_rdata_rst", 32'(rdata), 0);
    req = 3'b111; we_req = 3'b111;
    addr[0] = 17'd30; addr[1] = 17'd31; addr[2] = 17'd32;
    rst_n = 1'b1;
    step();
    chk("mr_first_gnt", 32'(gnt), 32'b001);
    chk("mr_no_rvalid", 32'(rvalid), 0);
    idle_inputs();
    step();
    chk("mr_no_rvalid2", 32'(rvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
